imem_loader: RTL and testbench

Byte-stream program loader that writes 16-bit instruction words into the CPU's instruction memory and holds the CPU in stall until a complete image is in place. It is the writer of the instruction store: it turns an external byte source (UART receiver, test harness) into `mem_we` / `mem_addr` / `mem_wdata` writes. It also releases `cpu_hold` so the 16-bit RISC core begins fetching from address 0.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/byte_pair_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 187 ++++++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader types and image-format constants
package cpu_pkg;

    localparam int WORD_W     = 16;
    localparam int HDR_BYTES  = 2;
    localparam bit BIG_ENDIAN = 1'b1;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } ld_state_e;

    function automatic logic accepts_bytes(input ld_state_e s);
        return s inside {LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CSUM};
    endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// rtl/byte_pair_assembler.sv - joins high/low stream bytes into one registered word strobe
module byte_pair_assembler
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              hi_en,
    input  logic              lo_en,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [7:0]        hi_q, hi_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    always_comb begin
        hi_d    = hi_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (hi_en) begin
            hi_d = byte_in;
        end
        if (lo_en) begin
            word_d  = BIG_ENDIAN ? {hi_q, byte_in} : {byte_in, hi_q};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream image loader writing instruction memory and holding the CPU
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the CSUM state.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    ld_state_e         state_q, state_d;
    logic              byte_ready_q, byte_ready_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              accept;
    logic              hi_en, lo_en;
    logic [15:0]       len_n;
    logic              last_word;

    assign accept    = byte_valid && byte_ready_q;
    assign len_n     = {len_hi_q, byte_in};
    assign last_word = (17'(cnt_q) + 17'd1) == {1'b0, len_q};

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        hi_en      = 1'b0;
        lo_en      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    state_d    = LD_LEN_HI;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            LD_LEN_HI: begin
                if (accept) begin
                    len_hi_d = byte_in;
                    state_d  = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (accept) begin
                    len_d = len_n;
                    cnt_d = '0;
                    if (len_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = LD_CSUM;
`else
                        state_d = LD_DONE;
`endif
                    end else if ({1'b0, len_n} > DEPTH) begin
                        state_d = LD_ERR;
                    end else begin
                        state_d = LD_DATA_HI;
                    end
                end
            end
            LD_DATA_HI: begin
                if (accept) begin
                    hi_en   = 1'b1;
                    state_d = LD_DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
`endif
                end
            end
            LD_DATA_LO: begin
                if (accept) begin
                    lo_en  = 1'b1;
                    addr_d = cnt_q[ADDR_W-1:0];
                    cnt_d  = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
                    state_d = last_word ? LD_CSUM : LD_DATA_HI;
`else
                    state_d = last_word ? LD_DONE : LD_DATA_HI;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (accept) begin
                    state_d = (byte_in == csum_q) ? LD_DONE : LD_ERR;
                end
            end
`endif
            default: state_d = LD_IDLE;
        endcase

        // Flags only change on the entry edge so a start from DONE/ERR can clear them.
        if (state_d == LD_DONE && state_q != LD_DONE) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
        end
        if (state_d == LD_ERR && state_q != LD_ERR) begin
            err_d = 1'b1;
        end

        byte_ready_d = accepts_bytes(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LD_IDLE;
            byte_ready_q <= 1'b0;
            len_hi_q     <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    byte_pair_assembler u_pair (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .hi_en      (hi_en),
        .lo_en      (lo_en),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

    assign byte_ready = byte_ready_q;
    assign mem_addr   = addr_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int            n_checks = 0;
    int            n_pass = 0;
    int            wr_cnt = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    logic [23:0]   exp_q[$];
    logic [15:0]   img[$];
    logic [7:0]    csum_flip = 8'h00;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("write_addr_data", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Streams the image held in img[]; expectations are queued as each word is sent.
    task automatic load(input logic [15:0] n, input bit gap, input bit mid_start);
        logic [7:0] x = 8'h00;
        send_byte(n[15:8]);
        if (gap) tick();
        send_byte(n[7:0]);
        for (int i = 0; i < int'(n); i++) begin
            if (gap) tick();
            exp_q.push_back({AW'(i), img[i]});
            send_byte(img[i][15:8]);
            if (mid_start && i == 0) begin
                pulse_start();
                check("mid_start_ready", 32'(byte_ready), 32'd1);
                check("mid_start_hold", 32'(cpu_hold), 32'd1);
            end
            if (gap) tick();
            send_byte(img[i][7:0]);
            x = x ^ img[i][15:8] ^ img[i][7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (gap) tick();
        send_byte(x ^ csum_flip);
`else
        x = x ^ csum_flip;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) tick();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full-rate N=3 image
        img = '{16'h1234, 16'hABCD, 16'h0001};
        w0 = wr_cnt;
        pulse_start();
        check("t1_ready_after_start", 32'(byte_ready), 32'd1);
        load(16'd3, 1'b0, 1'b0);
        check("t1_latency", 32'(cyc - start_cyc), 32'(2 + 2 * 3 + CS));
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_byte_ready", 32'(byte_ready), 32'd0);
        repeat (2) tick();
        check("t1_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t1_write_count", 32'(wr_cnt - w0), 32'd3);

        // Empty image
        w0 = wr_cnt;
        pulse_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        check("t2_hold_set", 32'(cpu_hold), 32'd1);
        load(16'd0, 1'b0, 1'b0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (2) tick();
        check("t2_no_writes", 32'(wr_cnt - w0), 32'd0);

        // Oversized length 257 for a 256-word store
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check("t3_err", 32'(err), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t3_byte_ready", 32'(byte_ready), 32'd0);
        byte_in = 8'h55;
        byte_valid = 1'b1;
        repeat (3) tick();
        byte_valid = 1'b0;
        check("t3_still_err", 32'(err), 32'd1);
        check("t3_no_writes", 32'(wr_cnt - w0), 32'd0);

        // Throttled N=2 with a start pulse mid-load
        img = '{16'h5AA5, 16'h0F1E};
        w0 = wr_cnt;
        pulse_start();
        check("t4_err_cleared", 32'(err), 32'd0);
        load(16'd2, 1'b1, 1'b1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (2) tick();
        check("t4_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t4_write_count", 32'(wr_cnt - w0), 32'd2);

        // Reset after the first data word, then a fresh load from address 0
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        exp_q.push_back({8'h00, 16'h1122});
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_mem_we", 32'(mem_we), 32'd0);
        check("t5_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_mem_wdata", 32'(mem_wdata), 32'd0);
        check("t5_byte_ready", 32'(byte_ready), 32'd0);
        check("t5_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_first_word_written", 32'(exp_q.size()), 32'd0);
        img = '{16'hCAFE, 16'hBEEF};
        w0 = wr_cnt;
        pulse_start();
        load(16'd2, 1'b0, 1'b0);
        check("t5_done_after_reload", 32'(done), 32'd1);
        repeat (2) tick();
        check("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t5_write_count", 32'(wr_cnt - w0), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: 0F^F0 = FF expected, 00 sent
        img = '{16'h0FF0};
        csum_flip = 8'hFF;
        w0 = wr_cnt;
        pulse_start();
        load(16'd1, 1'b0, 1'b0);
        csum_flip = 8'h00;
        check("t6_err", 32'(err), 32'd1);
        check("t6_done", 32'(done), 32'd0);
        check("t6_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (2) tick();
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t6_write_count", 32'(wr_cnt - w0), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
